tmr32_ctrl: RTL

Sequencing core behind the APB TIMER32 register wrapper. Consumes the software-visible control registers (PRE, TMRCMP, TMROVCLR, TMREN) and produces the live counter value (TMR) and sticky overflow flag (TMROV) that the wrapper reads back and turns into IRQ. It contains the prescaler, the 32-bit period counter, compare/reload logic, and the run/stop state machine.

---
 rtl/tmr32_pkg.sv | 8 +
 rtl/tmr32_prescaler.sv | 16 +
 rtl/tmr32_ctrl.sv | 53 +++++
 3 files changed

// File: rtl/tmr32_pkg.sv
// tmr32_pkg: state encoding, default width and reset values shared by the TIMER32 core
package tmr32_pkg;
  localparam int TMR32_W = 32;
  typedef enum logic [1:0] {STOP, RUN, DONE} tmr_state_e;
  localparam tmr_state_e STATE_RST = STOP;
  localparam logic TMROV_RST = 1'b0;
  localparam logic OVCLR_RST = 1'b0;
endpackage

// File: rtl/tmr32_prescaler.sv
// tmr32_prescaler: divides PCLK by PRE+1 while enabled and emits a one-cycle tick
module tmr32_prescaler import tmr32_pkg::*; #(parameter int W = TMR32_W) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] PRE,
  output logic         tick
);
  logic [W-1:0] cnt;
  // equality compare: a count already above a lowered PRE wraps through 2^W-1
  assign tick = enable && cnt == PRE;
  always_ff @(posedge PCLK)
    if (PRESET || clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/tmr32_ctrl.sv
// tmr32_ctrl: TIMER32 sequencing core (prescaler, period counter, overflow flag, run FSM);
// optional one-shot mode under `TMR32_ONESHOT_EN
module tmr32_ctrl import tmr32_pkg::*; #(parameter int W = TMR32_W) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic [W-1:0] PRE,
  input  logic [W-1:0] TMRCMP,
  input  logic         TMREN,
  input  logic         TMROVCLR,
  output logic [W-1:0] TMR,
  output logic         TMROV,
  output logic         tick,
  output logic         match
`ifdef TMR32_ONESHOT_EN
  ,
  input  logic         oneshot
`endif
);
  tmr_state_e state, state_nxt;
  logic ovclr_q, run_en, os, clr_edge;
`ifdef TMR32_ONESHOT_EN
  assign os = oneshot;
`else
  assign os = 1'b0;
`endif
  // qualifying with TMREN drops a tick that coincides with the enable falling
  assign run_en = state == RUN && TMREN;
  tmr32_prescaler #(.W(W)) u_psc (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .clear(!run_en),
    .enable(run_en),
    .PRE(PRE),
    .tick(tick)
  );
  assign match = tick && TMR == TMRCMP;
  assign clr_edge = TMROVCLR && !ovclr_q;
  always_comb begin
    state_nxt = !TMREN ? STOP : ((state == RUN && os && match) || state == DONE) ? DONE : RUN;
  end
  always_ff @(posedge PCLK)
    if (PRESET) begin
      state <= STATE_RST;
      TMR <= '0;
      TMROV <= TMROV_RST;
      ovclr_q <= OVCLR_RST;
    end else begin
      state <= state_nxt;
      ovclr_q <= TMROVCLR;
      if (tick) TMR <= match ? '0 : TMR + W'(1);
      TMROV <= match || (TMROV && !clr_edge);
    end
endmodule
